// File: rtl/seg7_pkg.sv
// seg7_pkg: segment patterns and FSM encodings shared by the seven-segment encoder and decoder.
package seg7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Active-low patterns for hex digits 0..F, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic [1:0] {IDLE, SETTLE, ACCEPT} state_t;
endpackage

// File: rtl/seg7_capture_if.sv
// seg7_capture_if: decoded-digit VALID/READY stream with error flag and sticky overflow.
interface seg7_capture_if;
    logic [3:0] CODE;
    logic       ERR;
    logic       VALID;
    logic       READY;
    logic       OVF;
    modport master(output CODE, ERR, VALID, OVF, input READY);
    modport slave(input CODE, ERR, VALID, OVF, output READY);
endinterface

// File: rtl/seg7_pattern_lookup.sv
// seg7_pattern_lookup: maps an active-low segment pattern back to its hex code, flagging unknown patterns.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] code_o,
    output logic       err_o
);
    always_comb begin
        code_o = 4'h0;
        err_o  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == SEG_TABLE[i]) begin
                code_o = 4'(i);
                err_o  = 1'b0;
            end
        end
    end
endmodule

// File: rtl/seg7_capture.sv
// seg7_capture: synchronises a segment bus, waits for a stable pattern and reports each new digit once.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [6:0] SEG_IN,
    seg7_capture_if.master out_if
);
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
    localparam logic             ONE_SHOT = (STABLE_CYCLES == 1);

    state_t           state_q;
    logic [6:0]       sync1_q, s_q, cand_q, last_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, lk_code;
    logic             err_q, valid_q, ovf_q, lk_err;

    seg7_pattern_lookup u_lookup (
        .pattern_i(cand_q),
        .code_o   (lk_code),
        .err_o    (lk_err)
    );

    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= SEG_BLANK;
            s_q     <= SEG_BLANK;
            cand_q  <= SEG_BLANK;
            last_q  <= SEG_BLANK;
            cnt_q   <= '0;
            state_q <= IDLE;
            code_q  <= 4'h0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= SEG_IN;
            s_q     <= sync1_q;
            if (valid_q && out_if.READY)
                valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_q == SEG_BLANK)
                        last_q <= SEG_BLANK;
                    else if (s_q != last_q) begin
                        cand_q  <= s_q;
                        cnt_q   <= CNT_W'(1);
                        state_q <= ONE_SHOT ? ACCEPT : SETTLE;
                    end
                end
                SETTLE: begin
                    if (s_q != cand_q) begin
                        cand_q <= s_q;
                        cnt_q  <= CNT_W'(1);
                        if (s_q == SEG_BLANK) begin
                            last_q  <= SEG_BLANK;
                            state_q <= IDLE;
                        end else if (s_q == last_q)
                            state_q <= IDLE;
                        else if (ONE_SHOT)
                            state_q <= ACCEPT;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d >= STABLE)
                            state_q <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    // Slot is overwritten even if unread; OVF records the lost value
                    last_q  <= cand_q;
                    code_q  <= lk_code;
                    err_q   <= lk_err;
                    valid_q <= 1'b1;
                    if (valid_q && !out_if.READY)
                        ovf_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_if.CODE  = code_q;
    assign out_if.ERR   = err_q;
    assign out_if.VALID = valid_q;
    assign out_if.OVF   = ovf_q;
endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: directed and table-driven checks of segment capture, handshake and overflow.
module tb_seg7_capture;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = 7'h24;
    int         checks = 0;
    int         errors = 0;

    seg7_capture_if bus();

    seg7_capture #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .SEG_IN  (seg),
        .out_if  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        logic       valid;
        logic [3:0] code;
        logic       err;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] v);
        @(negedge clk);
        seg = v;
    endtask

    // Expects VALID low for 6 cycles after the drive, then a report on the 7th
    task automatic wait_report(input string nm, input logic [3:0] code, input logic err);
        int early = 0;
        repeat (6) begin
            tick(1);
            if (bus.VALID) early++;
        end
        chk({nm, "_early"}, early, 0);
        tick(1);
        chk({nm, "_valid"}, bus.VALID, 1);
        chk({nm, "_code"}, bus.CODE, code);
        chk({nm, "_err"}, bus.ERR, err);
    endtask

    task automatic quiet(input string nm, input int n);
        int hi = 0;
        repeat (n) begin
            tick(1);
            if (bus.VALID) hi++;
        end
        chk(nm, hi, 0);
    endtask

    initial begin
        bus.READY = 1'b1;
        for (int i = 0; i < 16; i++)
            vecs[i] = '{seg7_pkg::SEG_TABLE[i], 1'b1, 4'(i), 1'b0};
        vecs[16] = '{7'h7E, 1'b1, 4'h0, 1'b1};
        vecs[17] = '{7'h7F, 1'b0, 4'h0, 1'b0};
        vecs[18] = '{7'h01, 1'b1, 4'h0, 1'b1};

        // 1: reset state and first report after release
        tick(3);
        @(negedge clk);
        chk("rst_code", bus.CODE, 0);
        chk("rst_err", bus.ERR, 0);
        chk("rst_valid", bus.VALID, 0);
        chk("rst_ovf", bus.OVF, 0);
        rst_n = 1'b1;
        wait_report("t1", 4'h2, 1'b0);
        quiet("t1_once", 12);

        // 2: bouncing input never settles, then final value reported
        begin
            int hi = 0;
            for (int i = 0; i < 10; i++) begin
                drive((i % 2) ? 7'h19 : 7'h12);
                repeat (2) begin
                    tick(1);
                    if (bus.VALID) hi++;
                end
            end
            chk("t2_bounce", hi, 0);
        end
        drive(7'h12);
        wait_report("t2", 4'h5, 1'b0);

        // 3: unknown pattern, blank never reported, repeat after blank
        drive(7'h7F);
        tick(4);
        drive(7'h55);
        wait_report("t3a", 4'h0, 1'b1);
        tick(3);
        drive(7'h7F);
        quiet("t3_blank", 8);
        drive(7'h55);
        wait_report("t3b", 4'h0, 1'b1);

        // 4: backpressure and overflow
        drive(7'h7F);
        tick(4);
        bus.READY = 1'b0;
        drive(7'h40);
        wait_report("t4a", 4'h0, 1'b0);
        tick(3);
        chk("t4_hold_valid", bus.VALID, 1);
        chk("t4_ovf_clear", bus.OVF, 0);
        drive(7'h0E);
        tick(6);
        chk("t4_code_held", bus.CODE, 0);
        chk("t4_ovf_pre", bus.OVF, 0);
        tick(1);
        chk("t4_code_new", bus.CODE, 4'hF);
        chk("t4_ovf", bus.OVF, 1);
        chk("t4_valid", bus.VALID, 1);
        tick(3);
        @(negedge clk);
        bus.READY = 1'b1;
        tick(1);
        chk("t4_drop", bus.VALID, 0);
        chk("t4_ovf_sticky", bus.OVF, 1);

        // 5: reset mid-settle discards the candidate
        drive(7'h7F);
        tick(4);
        drive(7'h30);
        tick(5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5_code", bus.CODE, 0);
        chk("t5_ovf", bus.OVF, 0);
        chk("t5_valid", bus.VALID, 0);
        chk("t5_err", bus.ERR, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_report("t5", 4'h3, 1'b0);

        // 6: table sweep with blanks between entries
        drive(7'h7F);
        tick(4);
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].seg);
            tick(6);
            chk($sformatf("v%0d_early", i), bus.VALID, 0);
            tick(1);
            chk($sformatf("v%0d_valid", i), bus.VALID, vecs[i].valid);
            if (vecs[i].valid) begin
                chk($sformatf("v%0d_code", i), bus.CODE, vecs[i].code);
                chk($sformatf("v%0d_err", i), bus.ERR, vecs[i].err);
            end
            chk($sformatf("v%0d_ovf", i), bus.OVF, 0);
            drive(7'h7F);
            tick(1);
            chk($sformatf("v%0d_pulse", i), bus.VALID, 0);
            tick(3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
